// File: rtl/clk_mon_pkg.sv
// Shared types and constants for the clock frequency monitor.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
//
// Contents:
//   mon_state_t      two-state measurement FSM encoding
//   DEF_CNT_W        default per-channel counter / result width
//   DEF_GATE_CYCLES  default gate window length in system clock cycles
//   clog2()          ceiling log2, used to size counters at elaboration

package clk_mon_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } mon_state_t;

  localparam int DEF_CNT_W       = 20;
  localparam int DEF_GATE_CYCLES = 100000;

  // Ceiling log2; clog2(1) = 0. Callers clamp the result to at least 1 bit.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/clk_freq_chan.sv
// One monitor channel: synchroniser, rising-edge counter, range check and lock tracking.
// Latency: an input edge is counted SYNC_STAGES+1 cycles later; results register on the gate-terminal cycle.
// Backpressure: none; the channel is slaved to the gate strobes from the top-level FSM.
//
// Ports:
//   clk, reset_n      system clock, async active-low reset
//   sig_in            asynchronous monitored signal
//   count_en          window is running, count edges this cycle
//   gate_terminal     last cycle of the window: publish result, restart count
//   clear             window aborted: drop partial count and lock history
//   min_cnt/max_cnt   inclusive unsigned limits, sampled on gate_terminal
//   meas_cnt          edge count of the last completed window
//   in_range          last window was within limits
//   locked            LOCK_WINDOWS consecutive in-range windows seen

module clk_freq_chan
  import clk_mon_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int SYNC_STAGES  = 2,
  parameter int LOCK_WINDOWS = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sig_in,
  input  logic             count_en,
  input  logic             gate_terminal,
  input  logic             clear,
  input  logic [CNT_W-1:0] min_cnt,
  input  logic [CNT_W-1:0] max_cnt,
  output logic [CNT_W-1:0] meas_cnt,
  output logic             in_range,
  output logic             locked
);

  localparam int GOOD_W = (clog2(LOCK_WINDOWS + 1) < 1) ? 1 : clog2(LOCK_WINDOWS + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_WINDOWS);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_prev_q;
  logic                   edge_pulse;
  logic [CNT_W-1:0]       edge_cnt_q;
  logic [CNT_W-1:0]       edge_cnt_inc;
  logic                   window_ok;
  logic [GOOD_W-1:0]      good_cnt_q;
  logic [GOOD_W-1:0]      good_cnt_d;

  // Synchroniser chain plus the previous-value flop for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q      <= '0;
      edge_prev_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], sig_in};
      edge_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_pulse = sync_q[SYNC_STAGES-1] & ~edge_prev_q;

  // Count including this cycle's edge; sticks at all-ones rather than wrapping
  // so an overspeed input can never alias back into the valid range.
  assign edge_cnt_inc = (edge_pulse && (edge_cnt_q != CNT_MAX)) ? edge_cnt_q + CNT_W'(1)
                                                                : edge_cnt_q;

  // Inclusive at both ends; min > max can never be satisfied.
  assign window_ok = (edge_cnt_inc >= min_cnt) && (edge_cnt_inc <= max_cnt);

  assign good_cnt_d = !window_ok                ? '0 :
                      (good_cnt_q == GOOD_MAX)  ? good_cnt_q :
                                                  good_cnt_q + GOOD_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_cnt_q <= '0;
      meas_cnt   <= '0;
      in_range   <= 1'b0;
      good_cnt_q <= '0;
      locked     <= 1'b0;
    end else if (clear) begin
      // Aborted window: published results stay, lock history restarts.
      edge_cnt_q <= '0;
      good_cnt_q <= '0;
      locked     <= 1'b0;
    end else if (gate_terminal) begin
      meas_cnt   <= edge_cnt_inc;
      in_range   <= window_ok;
      edge_cnt_q <= '0;
      good_cnt_q <= good_cnt_d;
      locked     <= (good_cnt_d == GOOD_MAX);
    end else if (count_en) begin
      edge_cnt_q <= edge_cnt_inc;
    end
  end

endmodule

// File: rtl/clk_freq_monitor.sv
// Multi-channel clock frequency and lock monitor over a fixed, back-to-back gate window.
// Latency: results and meas_valid appear the cycle after the last gate cycle; an input edge takes SYNC_STAGES+1 cycles to be counted.
// Backpressure: none; meas_valid is a one-cycle pulse and results hold until the next completed window.
//
// Ports:
//   clk, reset_n   system clock, async active-low reset
//   enable         1 runs windows continuously, 0 returns to idle and discards the partial window
//   sig_in         NUM_CH asynchronous monitored signals
//   min_cnt        per-channel lower limit, channel i at [i*CNT_W +: CNT_W]
//   max_cnt        per-channel upper limit, same packing
//   meas_cnt       per-channel edge count of the last completed window, same packing
//   meas_valid     one-cycle pulse when meas_cnt / in_range / locked update
//   in_range       per-channel result of the last window's limit check
//   locked         per-channel LOCK_WINDOWS consecutive in-range windows
//   busy           FSM is measuring

module clk_freq_monitor
  import clk_mon_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int GATE_CYCLES  = DEF_GATE_CYCLES,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int SYNC_STAGES  = 2,
  parameter int LOCK_WINDOWS = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [NUM_CH-1:0]       sig_in,
  input  logic [NUM_CH*CNT_W-1:0] min_cnt,
  input  logic [NUM_CH*CNT_W-1:0] max_cnt,
  output logic [NUM_CH*CNT_W-1:0] meas_cnt,
  output logic                    meas_valid,
  output logic [NUM_CH-1:0]       in_range,
  output logic [NUM_CH-1:0]       locked,
  output logic                    busy
);

  localparam int GATE_W = (clog2(GATE_CYCLES) < 1) ? 1 : clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  mon_state_t        state_q;
  mon_state_t        state_d;
  logic [GATE_W-1:0] gate_cnt_q;
  logic              gate_terminal;
  logic              abort;
  logic              count_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // enable is honoured every cycle, including the terminal one: dropping it on
  // the last gate cycle still discards the window rather than publishing it.
  always_comb begin
    state_d       = state_q;
    gate_terminal = 1'b0;
    abort         = 1'b0;
    count_en      = 1'b0;
    busy          = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        busy = 1'b1;
        if (!enable) begin
          state_d = IDLE;
          abort   = 1'b1;
        end else begin
          count_en      = 1'b1;
          gate_terminal = (gate_cnt_q == GATE_LAST);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Gate counter sits at zero outside a running window, so entry into
  // MEASURE always starts a full-length window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gate_cnt_q <= '0;
    end else if (count_en) begin
      gate_cnt_q <= gate_terminal ? '0 : gate_cnt_q + GATE_W'(1);
    end else begin
      gate_cnt_q <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meas_valid <= 1'b0;
    end else begin
      meas_valid <= gate_terminal;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    clk_freq_chan #(
      .CNT_W        (CNT_W),
      .SYNC_STAGES  (SYNC_STAGES),
      .LOCK_WINDOWS (LOCK_WINDOWS)
    ) u_chan (
      .clk           (clk),
      .reset_n       (reset_n),
      .sig_in        (sig_in[i]),
      .count_en      (count_en),
      .gate_terminal (gate_terminal),
      .clear         (abort),
      .min_cnt       (min_cnt[i*CNT_W +: CNT_W]),
      .max_cnt       (max_cnt[i*CNT_W +: CNT_W]),
      .meas_cnt      (meas_cnt[i*CNT_W +: CNT_W]),
      .in_range      (in_range[i]),
      .locked        (locked[i])
    );
  end

endmodule

// File: tb/tb_clk_freq_monitor.sv
// Directed bench for clk_freq_monitor: two instances (8-bit and 5-bit counters) share stimulus.
module tb_clk_freq_monitor;

  localparam int NCH   = 4;
  localparam int GATE  = 100;
  localparam int LOCKW = 4;
  localparam int WA    = 8;
  localparam int WB    = 5;

  logic               clk;
  logic               reset_n;
  logic               enable;
  logic [NCH-1:0]     sig_in;
  logic [NCH*WA-1:0]  min_a, max_a, meas_a;
  logic [NCH*WB-1:0]  min_b, max_b, meas_b;
  logic               vld_a, vld_b, busy_a, busy_b;
  logic [NCH-1:0]     inr_a, inr_b, lck_a, lck_b;

  int errors = 0;
  int checks = 0;

  int period [NCH] = '{default: 0};
  int epoch  [NCH] = '{default: 0};

  typedef struct {
    bit dut_b;
    int ch;
    int lo;
    int hi;
    bit inr;
    bit lck;
  } exp_t;

  exp_t sb [$];

  clk_freq_monitor #(.NUM_CH(NCH), .GATE_CYCLES(GATE), .CNT_W(WA), .SYNC_STAGES(2), .LOCK_WINDOWS(LOCKW)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .enable(enable), .sig_in(sig_in),
    .min_cnt(min_a), .max_cnt(max_a), .meas_cnt(meas_a), .meas_valid(vld_a),
    .in_range(inr_a), .locked(lck_a), .busy(busy_a));

  clk_freq_monitor #(.NUM_CH(NCH), .GATE_CYCLES(GATE), .CNT_W(WB), .SYNC_STAGES(2), .LOCK_WINDOWS(LOCKW)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .enable(enable), .sig_in(sig_in),
    .min_cnt(min_b), .max_cnt(max_b), .meas_cnt(meas_b), .meas_valid(vld_b),
    .in_range(inr_b), .locked(lck_b), .busy(busy_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Signal generator: period p>=2 gives a square wave (low first half), p=0 holds.
  // A new epoch restarts the phase so period changes land at a known point.
  initial begin
    int phase [NCH];
    int seen  [NCH];
    sig_in = '0;
    for (int c = 0; c < NCH; c++) begin
      phase[c] = 0;
      seen[c]  = 0;
    end
    forever begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
        if (seen[c] != epoch[c]) begin
          seen[c]  = epoch[c];
          phase[c] = 0;
        end
        if (period[c] >= 2) begin
          sig_in[c] = (phase[c] % period[c]) >= (period[c] / 2);
          phase[c]  = phase[c] + 1;
        end
      end
    end
  end

  task automatic set_period(input int c, input int p);
    period[c] = p;
    epoch[c]  = epoch[c] + 1;
  endtask

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input logic [31:0] got, input logic [31:0] lo, input logic [31:0] hi);
    checks++;
    assert (((got >= lo) && (got <= hi)) === 1'b1) else begin
      errors++;
      $error("FAIL %s got=%0d expected=%0d..%0d", tag, got, lo, hi);
    end
  endtask

  function automatic logic [31:0] meas_of(input bit b, input int ch);
    logic [31:0] r;
    if (b) r = 32'(meas_b[ch*WB +: WB]);
    else   r = 32'(meas_a[ch*WA +: WA]);
    return r;
  endfunction

  task automatic expect_ch(input bit b, input int ch, input int lo, input int hi, input bit inr, input bit lck);
    exp_t e;
    e.dut_b = b; e.ch = ch; e.lo = lo; e.hi = hi; e.inr = inr; e.lck = lck;
    sb.push_back(e);
  endtask

  // Wait for the next meas_valid (bounded), then drain the scoreboard against it.
  task automatic wait_window(input string tag, output int ncyc);
    bit   seen;
    exp_t e;
    string t;
    seen = 1'b0;
    ncyc = 0;
    for (int i = 1; i <= 150; i++) begin
      @(posedge clk);
      #1;
      if (vld_a) begin
        seen = 1'b1;
        ncyc = i;
        break;
      end
    end
    chk_eq({tag, "_valid_a"}, 32'(seen), 32'd1);
    chk_eq({tag, "_valid_b"}, 32'(vld_b), 32'd1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      t = $sformatf("%s_%s_ch%0d", tag, e.dut_b ? "B" : "A", e.ch);
      chk_rng({t, "_meas"}, meas_of(e.dut_b, e.ch), 32'(e.lo), 32'(e.hi));
      chk_eq({t, "_inr"}, 32'(e.dut_b ? inr_b[e.ch] : inr_a[e.ch]), 32'(e.inr));
      chk_eq({t, "_lck"}, 32'(e.dut_b ? lck_b[e.ch] : lck_a[e.ch]), 32'(e.lck));
    end
  endtask

  function automatic logic [NCH*WA-1:0] pack_a(input int l0, input int l1, input int l2, input int l3);
    return {WA'(l3), WA'(l2), WA'(l1), WA'(l0)};
  endfunction

  function automatic logic [NCH*WB-1:0] pack_b(input int l0, input int l1, input int l2, input int l3);
    return {WB'(l3), WB'(l2), WB'(l1), WB'(l0)};
  endfunction

  initial begin
    int ncyc;
    int pulses;
    reset_n = 1'b0;
    enable  = 1'b0;
    // ch0/ch1 9..11, ch2 min 12 > max 10, ch3 exactly 0..0
    min_a = pack_a(9, 9, 12, 0);
    max_a = pack_a(11, 11, 10, 0);
    min_b = pack_b(9, 9, 12, 0);
    max_b = pack_b(11, 11, 10, 0);
    set_period(0, 10);
    set_period(1, 4);
    set_period(2, 2);
    set_period(3, 0);

    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_meas_a", 32'(meas_a), 32'd0);
    chk_eq("rst_meas_b", 32'(meas_b), 32'd0);
    chk_eq("rst_valid", 32'(vld_a), 32'd0);
    chk_eq("rst_inr", 32'(inr_a), 32'd0);
    chk_eq("rst_lck", 32'(lck_a), 32'd0);
    chk_eq("rst_busy", 32'(busy_a), 32'd0);

    @(negedge clk);
    reset_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk_eq("idle_busy", 32'(busy_a), 32'd0);
    enable = 1'b1;
    @(posedge clk);
    #1;
    chk_eq("run_busy", 32'(busy_a), 32'd1);

    // Windows 1-4: ch0 and ch3 lock on the 4th, ch1 at 25 never in range, ch2 saturates on B.
    for (int w = 1; w <= 4; w++) begin
      expect_ch(0, 0, 9, 11, 1, w == 4);
      expect_ch(0, 1, 25, 25, 0, 0);
      expect_ch(0, 2, 50, 50, 0, 0);
      expect_ch(0, 3, 0, 0, 1, w == 4);
      expect_ch(1, 1, 25, 25, 0, 0);
      expect_ch(1, 2, 31, 31, 0, 0);
      expect_ch(1, 3, 0, 0, 1, w == 4);
      wait_window($sformatf("w%0d", w), ncyc);
    end

    // ch1 moves to period 10 at a window boundary: locks after exactly 4 more windows.
    set_period(1, 10);
    for (int w = 5; w <= 8; w++) begin
      expect_ch(0, 0, 9, 11, 1, 1);
      expect_ch(0, 1, (w == 5) ? 9 : 10, (w == 5) ? 11 : 10, 1, w == 8);
      expect_ch(1, 1, (w == 5) ? 9 : 10, (w == 5) ? 11 : 10, 1, w == 8);
      wait_window($sformatf("w%0d", w), ncyc);
    end

    // Freeze ch0 near the end of window 9 so window 10 is fully static.
    repeat (95) @(posedge clk);
    #1;
    set_period(0, 0);
    expect_ch(0, 0, 9, 11, 1, 1);
    expect_ch(0, 1, 10, 10, 1, 1);
    wait_window("w9", ncyc);
    expect_ch(0, 0, 0, 0, 0, 0);
    expect_ch(0, 1, 10, 10, 1, 1);
    expect_ch(0, 3, 0, 0, 1, 1);
    wait_window("w10_static", ncyc);
    set_period(0, 10);
    expect_ch(0, 0, 10, 10, 1, 0);
    wait_window("w11_relock", ncyc);

    // Drop enable mid-window: partial window discarded, lock cleared, results held.
    repeat (50) @(posedge clk);
    #1;
    enable = 1'b0;
    @(posedge clk);
    #1;
    chk_eq("abort_busy", 32'(busy_a), 32'd0);
    chk_eq("abort_lck_a", 32'(lck_a), 32'd0);
    chk_eq("abort_lck_b", 32'(lck_b), 32'd0);
    chk_eq("abort_inr_hold", 32'(inr_a), 32'b1011);
    chk_eq("abort_meas1_hold", meas_of(0, 1), 32'd10);
    chk_eq("abort_meas2_hold", meas_of(0, 2), 32'd50);
    chk_eq("abort_measb2_hold", meas_of(1, 2), 32'd31);
    pulses = 0;
    repeat (120) begin
      @(posedge clk);
      #1;
      if (vld_a || vld_b) pulses++;
    end
    chk_eq("idle_no_valid", 32'(pulses), 32'd0);

    enable = 1'b1;
    expect_ch(0, 0, 10, 10, 1, 0);
    expect_ch(0, 1, 10, 10, 1, 0);
    expect_ch(0, 3, 0, 0, 1, 0);
    wait_window("reen", ncyc);
    chk_eq("reen_latency", 32'(ncyc), 32'd101);

    // Async reset mid-window, then resume with enable still high.
    repeat (40) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #2;
    chk_eq("arst_meas_a", 32'(meas_a), 32'd0);
    chk_eq("arst_meas_b", 32'(meas_b), 32'd0);
    chk_eq("arst_inr", 32'(inr_a), 32'd0);
    chk_eq("arst_lck", 32'(lck_a), 32'd0);
    chk_eq("arst_busy", 32'(busy_a), 32'd0);
    chk_eq("arst_valid", 32'(vld_a), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    expect_ch(0, 1, 9, 11, 1, 0);
    expect_ch(0, 2, 49, 51, 0, 0);
    expect_ch(0, 3, 0, 0, 1, 0);
    expect_ch(1, 2, 31, 31, 0, 0);
    wait_window("post_rst1", ncyc);
    expect_ch(0, 1, 10, 10, 1, 0);
    expect_ch(0, 2, 50, 50, 0, 0);
    expect_ch(1, 3, 0, 0, 1, 0);
    wait_window("post_rst2", ncyc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
